ring_osc_meas_ctrl: RTL and testbench

- Digital sequencer for the on-die analog ring oscillator macro.
- Powers and trims the oscillator, waits for it to settle, then counts its (pre-divided) output over a fixed window of `clk` cycles. It latches the count for readout on the dedicated outputs.
- Sits between the tile's dedicated inputs/outputs and the analog ring macro's enable and trim pins.

---
 rtl/ring_osc_meas_ctrl.sv | 139 +++++++++++++
 tb/tb_ring_osc_meas_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_meas_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ring_osc_meas_ctrl                                                |
// | Brief   : Ring-oscillator sequencer: power/trim, settle, gated edge count.  |
// |           Optional back-to-back measurement when RO_CONTINUOUS_EN is set.   |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ring_osc_meas_ctrl #(
  parameter int COUNT_W       = 16,
  parameter int GATE_LOG2     = 10,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               cont,
  input  logic [2:0]         trim_sel,
  input  logic               osc_in,
  output logic               osc_en,
  output logic [2:0]         osc_trim,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [COUNT_W-1:0] count
);

  localparam int                       c_SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_SETTLE_W-1:0]    c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0]       c_CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_LATCH  = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_sync1, r_sync2, r_sync3;
  logic                    w_edge;
  logic                    w_cont;
  logic [c_SETTLE_W-1:0]   r_settle;
  logic [GATE_LOG2-1:0]    r_win;
  logic [COUNT_W-1:0]      r_edges;
  logic                    r_ovf;

`ifdef RO_CONTINUOUS_EN
  assign w_cont = cont;
`else
  logic w_unused_cont;
  assign w_unused_cont = cont;
  assign w_cont        = 1'b0;
`endif

  // osc_in is asynchronous: two flops to resolve metastability, third for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= osc_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_sync3;
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_win    <= '0;
      r_edges  <= '0;
      r_ovf    <= 1'b0;
      osc_en   <= 1'b0;
      osc_trim <= 3'd0;
      done     <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      if (!ena) begin
        r_state <= S_IDLE;
        osc_en  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              osc_trim <= trim_sel;
              osc_en   <= 1'b1;
              r_settle <= c_SETTLE_LOAD;
              r_state  <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_settle == '0) begin
              r_state <= S_GATE;
              r_win   <= '0;
              r_edges <= '0;
              r_ovf   <= 1'b0;
            end else begin
              r_settle <= r_settle - 1'b1;
            end
          end
          S_GATE: begin
            // An edge arriving with the counter already full is a lost edge
            if (w_edge) begin
              if (r_edges == c_CNT_MAX) r_ovf   <= 1'b1;
              else                      r_edges <= r_edges + 1'b1;
            end
            if (&r_win) r_state <= S_LATCH;
            r_win <= r_win + 1'b1;
          end
          S_LATCH: begin
            count    <= r_edges;
            overflow <= r_ovf;
            done     <= 1'b1;
            if (w_cont) begin
              r_state <= S_GATE;
              r_win   <= '0;
              r_edges <= '0;
              r_ovf   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              osc_en  <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_meas_ctrl.sv
`default_nettype none
// Directed bench for ring_osc_meas_ctrl: vector table of trim/period runs plus
// hand-written sequences for reset, mid-run disturbance, abort and continuous mode.
module tb_ring_osc_meas_ctrl;

  localparam int CW         = 6;
  localparam int GL         = 8;
  localparam int SC         = 8;
  localparam int DONE_EDGE  = SC + (1 << GL) + 1;
  localparam int CONT_GAP   = (1 << GL) + 1;

  logic          clk, rst_n, ena, start, cont, osc_in;
  logic [2:0]    trim_sel;
  logic          osc_en, busy, done, overflow;
  logic [2:0]    osc_trim;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  int osc_period = 8;
  bit osc_static = 1'b0;
  int phase      = 0;

  ring_osc_meas_ctrl #(.COUNT_W(CW), .GATE_LOG2(GL), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cont(cont),
    .trim_sel(trim_sel), .osc_in(osc_in), .osc_en(osc_en), .osc_trim(osc_trim),
    .busy(busy), .done(done), .overflow(overflow), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running oscillator; a window of 2^GL cycles holds exactly 2^GL/P rising edges
  initial begin
    osc_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      if (osc_static) osc_in = 1'b0;
      else            osc_in = ((phase % osc_period) >= (osc_period / 2));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Samples start on the following edge (edge 0); returns 1ns after edge 0
  task automatic launch(input logic [2:0] t);
    @(posedge clk);
    #1;
    trim_sel = t;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic watch(input int ncyc, output int ndone, output int first_done, output int last_done);
    ndone      = 0;
    first_done = -1;
    last_done  = -1;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = n;
        last_done = n;
      end
    end
  endtask

  typedef struct {
    logic [2:0] trim;
    int         period;
    int         exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nd, fd, ld;
    int trim_bad;

    vecs[0] = '{trim: 3'd5, period: 8,  exp_count: 32, exp_ovf: 1'b0};
    vecs[1] = '{trim: 3'd2, period: 4,  exp_count: 63, exp_ovf: 1'b1};
    vecs[2] = '{trim: 3'd7, period: 0,  exp_count: 0,  exp_ovf: 1'b0};
    vecs[3] = '{trim: 3'd1, period: 16, exp_count: 16, exp_ovf: 1'b0};
    vecs[4] = '{trim: 3'd0, period: 32, exp_count: 8,  exp_ovf: 1'b0};

    // Reset with start held high
    rst_n = 1'b0; ena = 1'b1; start = 1'b1; cont = 1'b0; trim_sel = 3'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_osc_en",   osc_en,   0);
    check("rst_osc_trim", osc_trim, 0);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_overflow", overflow, 0);
    check("rst_count",    count,    0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("rel_osc_trim", osc_trim, 3);
    check("rel_osc_en",   osc_en,   1);
    check("rel_busy",     busy,     1);

    // Abort the post-reset run with ena low
    repeat (20) @(posedge clk);
    #1;
    ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort0_osc_en", osc_en, 0);
    check("abort0_busy",   busy,   0);
    watch(300, nd, fd, ld);
    check("abort0_no_done", nd, 0);
    check("abort0_count",   count, 0);
    ena = 1'b1;

    // Table-driven measurements
    for (int i = 0; i < 5; i++) begin
      osc_static = (vecs[i].period == 0);
      if (vecs[i].period != 0) osc_period = vecs[i].period;
      launch(vecs[i].trim);
      @(negedge clk);
      check("vec_osc_en_run", osc_en,   1);
      check("vec_busy_run",   busy,     1);
      check("vec_trim",       osc_trim, 32'(vecs[i].trim));
      watch(DONE_EDGE, nd, fd, ld);
      check("vec_done_cnt",   nd, 1);
      check("vec_done_edge",  fd, DONE_EDGE);
      check("vec_count",      count,    vecs[i].exp_count);
      check("vec_overflow",   overflow, 32'(vecs[i].exp_ovf));
      check("vec_osc_en_end", osc_en,   0);
      check("vec_busy_end",   busy,     0);
      watch(20, nd, fd, ld);
      check("vec_done_single", nd, 0);
      check("vec_trim_hold",   osc_trim, 32'(vecs[i].trim));
    end
    osc_static = 1'b0;

    // start re-pulsed and trim_sel changed mid-GATE
    osc_period = 8;
    launch(3'd4);
    nd = 0; fd = -1; trim_bad = 0;
    for (int n = 1; n <= DONE_EDGE + 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 100) begin start = 1'b1; trim_sel = 3'd6; end
      if (n == 110) start = 1'b0;
      @(negedge clk);
      if (osc_trim !== 3'd4) trim_bad++;
      if (done === 1'b1) begin
        nd++;
        if (fd < 0) fd = n;
      end
    end
    check("midrun_done_cnt",  nd, 1);
    check("midrun_done_edge", fd, DONE_EDGE);
    check("midrun_count",     count, 32);
    check("midrun_trim_bad",  trim_bad, 0);

    // ena dropped mid-GATE keeps the previous result
    osc_period = 4;
    launch(3'd2);
    repeat (100) @(posedge clk);
    #1;
    ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_osc_en", osc_en, 0);
    check("abort_busy",   busy,   0);
    check("abort_done",   done,   0);
    watch(300, nd, fd, ld);
    check("abort_no_done",  nd, 0);
    check("abort_count",    count, 32);
    check("abort_overflow", overflow, 0);
    ena = 1'b1;

    // Continuous request
    osc_period = 16;
    cont = 1'b1;
    launch(3'd3);
    trim_sel = 3'd5;
    watch(DONE_EDGE, nd, fd, ld);
    check("cont_first_done", fd, DONE_EDGE);
    check("cont_first_cnt",  count, 16);
`ifdef RO_CONTINUOUS_EN
    check("cont_osc_en_1", osc_en, 1);
    check("cont_busy_1",   busy,   1);
    watch(CONT_GAP, nd, fd, ld);
    check("cont_done_2",   nd, 1);
    check("cont_edge_2",   ld, CONT_GAP);
    check("cont_count_2",  count, 16);
    check("cont_osc_en_2", osc_en, 1);
    check("cont_trim_2",   osc_trim, 3);
    cont = 1'b0;
    watch(CONT_GAP, nd, fd, ld);
    check("cont_done_3",   nd, 1);
    check("cont_edge_3",   ld, CONT_GAP);
    check("cont_count_3",  count, 16);
    check("cont_osc_en_3", osc_en, 0);
    check("cont_busy_3",   busy,   0);
`else
    check("nocont_osc_en", osc_en, 0);
    check("nocont_busy",   busy,   0);
`endif
    cont = 1'b0;
    watch(300, nd, fd, ld);
    check("cont_tail_no_done", nd, 0);
    check("cont_tail_busy",    busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
